fifo_byte_serializer: RTL and testbench
=======================================

# fifo_byte_serializer

Read-side companion to the byte-packing FIFO path: drains 8-bit words from a FIFO64x8 read port and re-emits each word downstream either as one full byte or as two nibbles (high first), with a start flag on the first beat and ready/valid backpressure. It sits between the FIFO's read interface and the outbound link, mirroring the converter that fills the FIFO.

## Interface
Parameters:
- WIDTH, 8, FIFO word width; must be even; nibble width is WIDTH/2.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- byte  in  1  mode: 1 = one beat per word, 0 = two half-word beats; sampled when a word is captured.
- fifo_empty  in  1  FIFO empty flag.
- fifo_data  in  WIDTH  FIFO read data, valid the cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe (combinational).
- out_ready  in  1  downstream accepts current beat.
- data_o  out  WIDTH  beat data; nibble beats are zero-extended in the low half.
- data_en  out  1  beat valid.
- start_o  out  1  high with the first beat of each word.

## Operation
- States: IDLE, WAIT, HOLD_HI, HOLD_LO.
- IDLE: fifo_rd_en = !fifo_empty; if asserted, go to WAIT.
- WAIT: register fifo_data into word_r, byte into mode_r, and load outputs.
  - Byte mode: data_o = word_r.
  - Nibble mode: data_o = {0, word[WIDTH-1:WIDTH/2]}.
  - Set data_en = 1 and start_o = 1, then go to HOLD_HI.
- HOLD_HI: hold all outputs while out_ready = 0. On out_ready = 1:
  - mode_r = 0: data_o = {0, word_r[WIDTH/2-1:0]}, start_o = 0, go to HOLD_LO.
  - mode_r = 1: word done (see below).
- HOLD_LO: hold while out_ready = 0; on out_ready = 1, word done.
- Word done:
  - Clear data_en and start_o.
  - If !fifo_empty: fifo_rd_en = 1 in the same cycle, go to WAIT.
  - Else go to IDLE.
- fifo_rd_en is asserted only in IDLE or on a word-done cycle, never while the FIFO is empty, and at most once per word.
- A change on byte while a word is in flight has no effect until the next capture.

## Timing
- Reset values: data_o = 0, data_en = 0, start_o = 0, state IDLE, word_r = 0, mode_r = 1. fifo_rd_en = 0 while reset is asserted.
- Latency: from fifo_rd_en high to data_en high is 2 edges (FIFO read cycle, then capture in WAIT).
- Throughput with out_ready held high: 1 word per 2 cycles in byte mode, 1 word per 3 cycles in nibble mode.
- data_en, data_o and start_o are registered and change only on a clk edge.
- A beat is transferred on an edge where data_en & out_ready.
- data_en may drop only after a transfer.
- Empty FIFO: the block idles with data_en = 0 and never reads.
- out_ready stalled indefinitely: outputs stay stable and no FIFO reads occur.
- FIFO goes non-empty on the same edge as word done: it is detected next cycle from IDLE (one extra bubble).
- Reset mid-word: outputs clear immediately; the partially sent word is dropped and not re-read.

## Structure
- Shared include/package (with the existing converter constants): state encodings ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_HOLD_HI = 2'd2, ST_HOLD_LO = 2'd3.
- Single module, no sub-modules.
- Top-level pairing: a wrapper, fifo_to_link, may instantiate FIFO64x8 plus this block; it is out of scope here.

## Test plan
- Byte mode, FIFO preloaded with 0x3C, 0xA5, out_ready = 1:
  - fifo_rd_en pulses twice.
  - Beats 0x3C then 0xA5, each with start_o = 1.
  - data_en high one cycle in two.
- Nibble mode, word 0xA5:
  - Beats 0x0A (start_o = 1) then 0x05 (start_o = 0).
  - Next fifo_rd_en occurs on the 0x05 accept cycle.
- Backpressure: out_ready = 0 for 5 cycles during beat 0x0A:
  - data_o, data_en and start_o stay constant.
  - fifo_rd_en stays 0.
  - Sequence resumes correctly after release.
- Empty FIFO for 20 cycles, then one word 0x7E is written:
  - No reads while empty.
  - Single beat 0x7E appears 2 edges after fifo_rd_en.
- Mode toggle: byte flips from 1 to 0 during HOLD_HI of word 0x11:
  - 0x11 is still sent as one beat.
  - Next word 0x22 is sent as 0x02, 0x02.
- Reset pulse during HOLD_LO:
  - All outputs go to 0 asynchronously.
  - After release the next FIFO word is read and emitted from its first beat.

Source files
------------

// File: rtl/fifo_byte_serializer_pkg.sv
// rtl/fifo_byte_serializer_pkg.sv - shared constants for the FIFO byte/nibble serializer
// Purpose: state encodings and mode constants used by the serializer.
// Ports: none (package).
package fifo_byte_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_HOLD_HI = 2'd2,
    ST_HOLD_LO = 2'd3
  } state_e;

  localparam int unsigned DEF_WIDTH = 8;
  localparam logic        MODE_BYTE = 1'b1;

endpackage

// File: rtl/fifo_byte_serializer.sv
// rtl/fifo_byte_serializer.sv - drains a FIFO read port into byte or nibble beats
// Purpose: reads one word at a time from a FIFO and emits it downstream as one
//   full-width beat (byte mode) or two half-width beats, high half first.
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   byte_i     - 1 = one beat per word, 0 = two half-word beats (sampled on capture)
//   fifo_empty - FIFO empty flag
//   fifo_data  - FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en - FIFO read strobe (combinational)
//   out_ready  - downstream accepts the current beat
//   data_o     - beat data; half-word beats are zero-extended
//   data_en    - beat valid
//   start_o    - high with the first beat of each word
module fifo_byte_serializer
  import fifo_byte_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             byte_i,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_rd_en,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_o,
  output logic             data_en,
  output logic             start_o
);

  localparam int unsigned HALF = WIDTH / 2;

  state_e           state_q;
  logic [WIDTH-1:0] word_q;
  logic             mode_q;
  logic [WIDTH-1:0] data_q;
  logic             data_en_q;
  logic             start_q;
  logic             word_done;

  function automatic logic [WIDTH-1:0] hi_half(input logic [WIDTH-1:0] w);
    return {{HALF{1'b0}}, w[WIDTH-1:HALF]};
  endfunction

  function automatic logic [WIDTH-1:0] lo_half(input logic [WIDTH-1:0] w);
    return {{HALF{1'b0}}, w[HALF-1:0]};
  endfunction

  // Last beat of the current word is being accepted this cycle.
  always_comb begin
    word_done = 1'b0;
    if (out_ready) begin
      case (state_q)
        ST_HOLD_HI: word_done = mode_q;
        ST_HOLD_LO: word_done = 1'b1;
        default:    word_done = 1'b0;
      endcase
    end
  end

  // Reading on the word-done cycle lets the next word be captured without
  // passing through IDLE; reset gates the strobe so no word is lost.
  assign fifo_rd_en = !reset && !fifo_empty && ((state_q == ST_IDLE) || word_done);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      mode_q    <= MODE_BYTE;
      data_q    <= '0;
      data_en_q <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (fifo_rd_en) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          word_q    <= fifo_data;
          mode_q    <= byte_i;
          data_q    <= byte_i ? fifo_data : hi_half(fifo_data);
          data_en_q <= 1'b1;
          start_q   <= 1'b1;
          state_q   <= ST_HOLD_HI;
        end
        ST_HOLD_HI: begin
          if (out_ready) begin
            if (mode_q) begin
              data_en_q <= 1'b0;
              start_q   <= 1'b0;
              state_q   <= fifo_rd_en ? ST_WAIT : ST_IDLE;
            end else begin
              data_q  <= lo_half(word_q);
              start_q <= 1'b0;
              state_q <= ST_HOLD_LO;
            end
          end
        end
        ST_HOLD_LO: begin
          if (out_ready) begin
            data_en_q <= 1'b0;
            start_q   <= 1'b0;
            state_q   <= fifo_rd_en ? ST_WAIT : ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data_o  = data_q;
  assign data_en = data_en_q;
  assign start_o = start_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// tb/tb_fifo_byte_serializer.sv - scoreboard bench for fifo_byte_serializer
// Purpose: FIFO model feeds the serializer; expected beats are queued when
//   words are written and compared as beats are accepted downstream.
// Ports: none (top-level bench).
module tb_fifo_byte_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_i;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       out_ready;
  logic [7:0] data_o;
  logic       data_en;
  logic       start_o;

  always #5 clk = ~clk;

  fifo_byte_serializer #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_i     (byte_i),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .out_ready  (out_ready),
    .data_o     (data_o),
    .data_en    (data_en),
    .start_o    (start_o)
  );

  logic [7:0] mem[$];
  // Scoreboard entry: {present, start, data}.
  logic [9:0] exp_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int n_reads  = 0;
  int cyc      = 0;
  int last_rd  = -1;
  int exp_gap  = 0;
  int r0;

  logic       prev_en    = 1'b0;
  logic       prev_start = 1'b0;
  logic       prev_ready = 1'b1;
  logic [7:0] prev_data  = 8'h00;
  logic [9:0] want;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO read port: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (fifo_rd_en && mem.size() > 0) begin
      fifo_data  <= mem.pop_front();
      fifo_empty <= (mem.size() == 0);
      n_reads++;
    end
  end

  // Monitor samples on the falling edge, midway between active edges.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_en    = 1'b0;
      prev_start = 1'b0;
      prev_ready = 1'b1;
    end else begin
      if (prev_en && !prev_ready) begin
        chk("stall_data", data_o, prev_data);
        chk("stall_en", data_en, 1);
        chk("stall_start", start_o, prev_start);
      end
      if (data_en && start_o && !(prev_en && prev_start))
        chk("latency", cyc - last_rd, 2);
      if (fifo_rd_en) begin
        chk("rd_not_empty", fifo_empty, 0);
        chk("rd_not_stalled", data_en & ~out_ready, 0);
        if (exp_gap != 0 && last_rd >= 0)
          chk("rd_gap", cyc - last_rd, exp_gap);
        last_rd = cyc;
      end
      if (data_en && out_ready) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h000;
        chk("beat", {1'b1, start_o, data_o}, want);
      end
      prev_en    = data_en;
      prev_start = start_o;
      prev_ready = out_ready;
      prev_data  = data_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] w, input logic m);
    mem.push_back(w);
    fifo_empty = 1'b0;
    if (m) begin
      exp_q.push_back({2'b11, w});
    end else begin
      exp_q.push_back({2'b11, 4'h0, w[7:4]});
      exp_q.push_back({2'b10, 4'h0, w[3:0]});
    end
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((exp_q.size() != 0 || mem.size() != 0) && i < budget) begin
      tick(1);
      i++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    tick(3);
  endtask

  task automatic wait_beat(input int budget);
    int i = 0;
    while (!(data_en && start_o) && i < budget) begin
      tick(1);
      i++;
    end
    chk("beat_timeout", data_en & start_o, 1);
  endtask

  initial begin
    reset      = 1'b1;
    byte_i     = 1'b1;
    out_ready  = 1'b1;
    fifo_empty = 1'b0;
    fifo_data  = 8'h00;
    #2;
    chk("rst_data", data_o, 0);
    chk("rst_en", data_en, 0);
    chk("rst_start", start_o, 0);
    chk("rst_rd", fifo_rd_en, 0);
    fifo_empty = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tick(2);

    // Byte mode, two preloaded words, streaming.
    exp_gap = 2; last_rd = -1; r0 = n_reads; byte_i = 1'b1;
    push_word(8'h3C, 1'b1);
    push_word(8'hA5, 1'b1);
    wait_drain(50);
    chk("p1_reads", n_reads - r0, 2);

    // Nibble mode, streaming.
    exp_gap = 3; last_rd = -1; r0 = n_reads; byte_i = 1'b0;
    push_word(8'hA5, 1'b0);
    push_word(8'h3C, 1'b0);
    wait_drain(50);
    chk("p2_reads", n_reads - r0, 2);

    // Backpressure for 5 cycles on the first nibble beat.
    exp_gap = 0; r0 = n_reads; byte_i = 1'b0;
    push_word(8'hA5, 1'b0);
    push_word(8'h5A, 1'b0);
    wait_beat(20);
    chk("p3_first_beat", data_o, 8'h0A);
    out_ready = 1'b0;
    tick(5);
    chk("p3_stall_reads", n_reads - r0, 1);
    chk("p3_stall_data", data_o, 8'h0A);
    out_ready = 1'b1;
    wait_drain(50);
    chk("p3_reads", n_reads - r0, 2);

    // Empty FIFO idles, then a single word arrives.
    r0 = n_reads; byte_i = 1'b1;
    tick(20);
    chk("p4_idle_reads", n_reads - r0, 0);
    chk("p4_idle_en", data_en, 0);
    push_word(8'h7E, 1'b1);
    wait_drain(50);
    chk("p4_reads", n_reads - r0, 1);

    // Mode flips while the first word is held.
    r0 = n_reads; out_ready = 1'b0; byte_i = 1'b1;
    push_word(8'h11, 1'b1);
    wait_beat(20);
    chk("p5_held", data_o, 8'h11);
    byte_i = 1'b0;
    push_word(8'h22, 1'b0);
    tick(2);
    out_ready = 1'b1;
    wait_drain(50);
    chk("p5_reads", n_reads - r0, 2);

    // Reset while holding the low nibble: that beat is dropped.
    r0 = n_reads; out_ready = 1'b0; byte_i = 1'b0;
    mem.push_back(8'h96);
    fifo_empty = 1'b0;
    exp_q.push_back({2'b11, 8'h09});
    push_word(8'h4B, 1'b0);
    wait_beat(20);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    chk("p6_lo_data", data_o, 8'h06);
    chk("p6_lo_start", start_o, 0);
    #2;
    reset = 1'b1;
    #1;
    chk("p6_rst_data", data_o, 0);
    chk("p6_rst_en", data_en, 0);
    chk("p6_rst_start", start_o, 0);
    chk("p6_rst_rd", fifo_rd_en, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    tick(1);
    out_ready = 1'b1;
    wait_drain(50);
    chk("p6_reads", n_reads - r0, 2);

    chk("total_reads", n_reads, 11);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
